// File: rtl/arb_req_mux.sv
// Requester-side companion to a fixed-priority arbiter: per-channel depth-1
// holding slots feed the arbiter's request vector; the granted slot moves into a registered output stage.
module arb_req_mux #(
   parameter int WIDTH = 4,
   parameter int DW    = 8,
   parameter int IDW   = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WIDTH-1:0]    in_vld,
   output logic [WIDTH-1:0]    in_rdy,
   input  logic [WIDTH*DW-1:0] in_data,
   output logic [WIDTH-1:0]    arb_vld,
   input  logic [WIDTH-1:0]    arb_grant,
   output logic                out_vld,
   input  logic                out_rdy,
   output logic [DW-1:0]       out_data,
   output logic [IDW-1:0]      out_id,
   output logic                err_grant
);

   logic [WIDTH-1:0] hold_vld;
   logic [DW-1:0]    hold_data [WIDTH];

   logic             out_free;
   logic             grant_one_hot;
   logic             grant_ok;
   logic             grant_bad;
   logic             xfer;
   logic [WIDTH-1:0] drain;
   logic [WIDTH-1:0] accept;
   logic [IDW-1:0]   grant_idx;

   assign arb_vld  = hold_vld;
   assign out_free = ~out_vld | out_rdy;

   assign grant_one_hot = (arb_grant != '0) &&
                          ((arb_grant & (arb_grant - WIDTH'(1))) == '0);
   assign grant_ok  = grant_one_hot && ((arb_grant & ~hold_vld) == '0);
   // A zero grant is a legal stall; anything else that is not a clean one-hot hit on an occupied slot is an error.
   assign grant_bad = (arb_grant != '0) && !grant_ok;
   assign xfer      = out_free & grant_ok;

   assign drain  = xfer ? arb_grant : '0;
   assign in_rdy = ~hold_vld | drain;
   assign accept = in_vld & in_rdy;

   // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (arb_grant[i]) grant_idx = IDW'(i);
      end
   end

   // NOTE: the payload slots are reset too, so no stale data survives a mid-operation reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld <= '0;
         for (int i = 0; i < WIDTH; i++) hold_data[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (accept[i]) begin
               hold_vld[i]  <= 1'b1;
               hold_data[i] <= in_data[i*DW +: DW];
            end else if (drain[i]) begin
               hold_vld[i]  <= 1'b0;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_id   <= '0;
      end else if (xfer) begin
         out_vld  <= 1'b1;
         out_data <= hold_data[grant_idx];
         out_id   <= grant_idx;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         err_grant <= 1'b0;
      else if (grant_bad) err_grant <= 1'b1;
   end

endmodule
